// File: rtl/donkey_move_ctl.sv
// Donkey movement controller: turns key levels into the sprite's top-left
// position, with timer-paced walking and a fixed-height jump/fall profile.
module donkey_move_ctl #(
  parameter int MOVE_STEP_CYCLES = 250_000,
  parameter int JUMP_STEP_CYCLES = 1_400_000,
  parameter int JUMP_HEIGHT      = 61,
  parameter int CHAR_WIDTH       = 48,
  parameter int SCREEN_WIDTH     = 1024,
  parameter int INITIAL_XPOS     = 128,
  parameter int INITIAL_YPOS     = 672
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left,
  input  logic        right,
  input  logic        jump,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        jumping,
  output logic        facing_left
);

  localparam int MW = (MOVE_STEP_CYCLES > 1) ? $clog2(MOVE_STEP_CYCLES) : 1;
  localparam int JW = (JUMP_STEP_CYCLES > 1) ? $clog2(JUMP_STEP_CYCLES) : 1;
  localparam int HW = $clog2(JUMP_HEIGHT + 1);

  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_STEP_CYCLES - 1);
  localparam logic [JW-1:0] JUMP_LAST = JW'(JUMP_STEP_CYCLES - 1);
  localparam logic [HW-1:0] H_TOP     = HW'(JUMP_HEIGHT);
  localparam logic [11:0]   X_MAX     = 12'(SCREEN_WIDTH - CHAR_WIDTH);
  localparam logic [11:0]   X_INIT    = 12'(INITIAL_XPOS);
  localparam logic [11:0]   Y_GROUND  = 12'(INITIAL_YPOS);

  typedef enum logic [1:0] {
    S_GROUND  = 2'd0,
    S_JUMP_UP = 2'd1,
    S_FALL    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [MW-1:0]   r_move_cnt;
  logic [JW-1:0]   r_jump_cnt;
  logic [JW-1:0]   w_jump_cnt_nxt;
  logic [HW-1:0]   r_height_cnt;
  logic [HW-1:0]   w_height_nxt;
  logic [HW-1:0]   w_height_inc;
  logic [11:0]     r_xpos;
  logic [11:0]     r_ypos;
  logic [11:0]     w_ypos_nxt;
  logic            r_jumping;
  logic            r_facing_left;
  logic            r_jump_prev;
  logic            w_move_req;
  logic            w_jump_rise;
  logic            w_jump_wrap;

  assign w_move_req   = left ^ right;
  assign w_jump_rise  = jump & ~r_jump_prev;
  assign w_jump_wrap  = (r_jump_cnt == JUMP_LAST);
  assign w_height_inc = r_height_cnt + HW'(1);

  // Horizontal walking: a tick every MOVE_STEP_CYCLES held cycles; clamped ticks still set facing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_move_cnt    <= '0;
      r_xpos        <= X_INIT;
      r_facing_left <= 1'b0;
    end else if (!w_move_req) begin
      r_move_cnt <= '0;
    end else if (r_move_cnt == MOVE_LAST) begin
      r_move_cnt    <= '0;
      r_facing_left <= left;
      if (left) begin
        if (r_xpos != 12'd0) r_xpos <= r_xpos - 12'd1;
      end else begin
        if (r_xpos < X_MAX) r_xpos <= r_xpos + 12'd1;
      end
    end else begin
      r_move_cnt <= r_move_cnt + MW'(1);
    end
  end

  // Jump state machine next-state and vertical position.
  always_comb begin
    w_state_nxt    = r_state;
    w_jump_cnt_nxt = r_jump_cnt;
    w_height_nxt   = r_height_cnt;
    w_ypos_nxt     = r_ypos;
    case (r_state)
      S_GROUND: begin
        w_ypos_nxt = Y_GROUND;
        if (w_jump_rise) begin
          w_state_nxt    = S_JUMP_UP;
          w_jump_cnt_nxt = '0;
          w_height_nxt   = '0;
        end
      end
      S_JUMP_UP: begin
        if (w_jump_wrap) begin
          w_jump_cnt_nxt = '0;
          w_ypos_nxt     = r_ypos - 12'd1;
          w_height_nxt   = w_height_inc;
          if (w_height_inc == H_TOP) w_state_nxt = S_FALL;
        end else begin
          w_jump_cnt_nxt = r_jump_cnt + JW'(1);
        end
      end
      S_FALL: begin
        if (w_jump_wrap) begin
          w_jump_cnt_nxt = '0;
          w_ypos_nxt     = r_ypos + 12'd1;
          if (r_ypos + 12'd1 == Y_GROUND) w_state_nxt = S_GROUND;
        end else begin
          w_jump_cnt_nxt = r_jump_cnt + JW'(1);
        end
      end
      default: begin
        w_state_nxt    = S_GROUND;
        w_jump_cnt_nxt = '0;
        w_height_nxt   = '0;
        w_ypos_nxt     = Y_GROUND;
      end
    endcase
  end

  // Jump state register; jumping is registered alongside the state it reflects.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_GROUND;
      r_jump_cnt   <= '0;
      r_height_cnt <= '0;
      r_ypos       <= Y_GROUND;
      r_jumping    <= 1'b0;
      r_jump_prev  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_jump_cnt   <= w_jump_cnt_nxt;
      r_height_cnt <= w_height_nxt;
      r_ypos       <= w_ypos_nxt;
      r_jumping    <= (w_state_nxt != S_GROUND);
      r_jump_prev  <= jump;
    end
  end

  assign xpos        = r_xpos;
  assign ypos        = r_ypos;
  assign jumping     = r_jumping;
  assign facing_left = r_facing_left;

endmodule

// File: tb/tb_donkey_move_ctl.sv
// Scoreboard bench for donkey_move_ctl: a timeline-based reference model
// predicts the outputs of every cycle; a monitor compares them after each edge.
module tb_donkey_move_ctl;

  localparam int M  = 4;
  localparam int J  = 3;
  localparam int H  = 5;
  localparam int XI = 128;
  localparam int YG = 672;
  localparam int XM = 1024 - 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        left = 1'b0, right = 1'b0, jump = 1'b0;
  logic [11:0] xpos, ypos;
  logic        jumping, facing_left;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        j;
    logic        f;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state: position, held-run length, time since jump start
  int m_x = XI, m_run = 0, m_jt = -1;
  bit m_fl = 1'b0, m_prev = 1'b0;

  donkey_move_ctl #(
    .MOVE_STEP_CYCLES(M), .JUMP_STEP_CYCLES(J), .JUMP_HEIGHT(H),
    .CHAR_WIDTH(48), .SCREEN_WIDTH(1024), .INITIAL_XPOS(XI), .INITIAL_YPOS(YG)
  ) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .jump(jump),
    .xpos(xpos), .ypos(ypos), .jumping(jumping), .facing_left(facing_left)
  );

  always #5 clk = ~clk;

  function automatic int exp_y(input int jt);
    if (jt < 0) return YG;
    if (jt <= H * J) return YG - jt / J;
    return YG - H + (jt - H * J) / J;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit l, input bit r, input bit j, input bit rs);
    bit rise;
    if (rs) begin
      m_x = XI; m_fl = 1'b0; m_run = 0; m_jt = -1; m_prev = 1'b0;
      return;
    end
    if (l ^ r) begin
      m_run++;
      if (m_run % M == 0) begin
        m_fl = l;
        if (l) m_x = (m_x > 0) ? m_x - 1 : 0;
        else   m_x = (m_x < XM) ? m_x + 1 : XM;
      end
    end else begin
      m_run = 0;
    end
    rise = j & ~m_prev;
    m_prev = j;
    if (m_jt >= 0) begin
      m_jt++;
      if (m_jt == 2 * H * J) m_jt = -1;
    end else if (rise) begin
      m_jt = 0;
    end
  endtask

  task automatic drive(input bit l, input bit r, input bit j, input bit rs);
    exp_t e;
    @(negedge clk);
    left = l; right = r; jump = j; rst = rs;
    model(l, r, j, rs);
    e.x = 12'(m_x);
    e.y = 12'(exp_y(m_jt));
    e.j = (m_jt >= 0);
    e.f = m_fl;
    sb_q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: one expected entry per issued cycle, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_xpos", int'(xpos), int'(mon_e.x));
      chk("sb_ypos", int'(ypos), int'(mon_e.y));
      chk("sb_jumping", int'(jumping), int'(mon_e.j));
      chk("sb_facing_left", int'(facing_left), int'(mon_e.f));
    end
  end

  initial begin
    bit l, r, j;
    repeat (2) drive(0, 0, 0, 1);
    settle();
    chk("reset_xpos", int'(xpos), 128);
    chk("reset_ypos", int'(ypos), 672);
    chk("reset_jumping", int'(jumping), 0);

    repeat (12) drive(0, 1, 0, 0);
    settle();
    chk("right12_xpos", int'(xpos), 131);
    chk("right12_facing", int'(facing_left), 0);

    repeat (20) drive(1, 1, 0, 0);
    repeat (8) drive(1, 0, 0, 0);
    settle();
    chk("both_then_left_xpos", int'(xpos), 129);
    chk("left8_facing", int'(facing_left), 1);

    repeat (600) drive(1, 0, 0, 0);
    settle();
    chk("clamp_low_xpos", int'(xpos), 0);
    drive(0, 0, 0, 0);
    repeat (8) drive(1, 0, 0, 0);
    settle();
    chk("clamp_low_hold_xpos", int'(xpos), 0);
    chk("clamp_low_facing", int'(facing_left), 1);

    repeat (3950) drive(0, 1, 0, 0);
    settle();
    chk("clamp_high_xpos", int'(xpos), 976);

    drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);
    settle();
    chk("jump_start_jumping", int'(jumping), 1);
    repeat (15) drive(0, 0, 0, 0);
    settle();
    chk("jump_apex_ypos", int'(ypos), 667);
    repeat (15) drive(0, 0, 0, 0);
    settle();
    chk("jump_land_ypos", int'(ypos), 672);
    chk("jump_land_jumping", int'(jumping), 0);

    repeat (40) drive(0, 1, 1, 0);
    settle();
    chk("held_jump_no_retrigger", int'(jumping), 0);
    chk("midair_walk_xpos", int'(xpos), 138);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    settle();
    chk("repress_jumping", int'(jumping), 1);

    repeat (21) drive(0, 0, 0, 0);
    settle();
    chk("fall_ypos_669", int'(ypos), 669);
    drive(0, 0, 0, 1);
    settle();
    chk("rst_midjump_ypos", int'(ypos), 672);
    chk("rst_midjump_xpos", int'(xpos), 128);
    chk("rst_midjump_jumping", int'(jumping), 0);

    l = 0; r = 0; j = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) l = $urandom_range(1);
      if ($urandom_range(7) == 0) r = $urandom_range(1);
      if ($urandom_range(5) == 0) j = $urandom_range(1);
      drive(l, r, j, ($urandom_range(499) == 0));
    end
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
